// File: rtl/unidade_de_controle_pkg.sv
// Shared encodings, state type and small decode helpers for unidade_de_controle.
package unidade_de_controle_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [3:0] SEL_IMM = 4'd0;
  localparam logic [3:0] SEL_R0  = 4'd1;
  localparam logic [3:0] SEL_G   = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  function automatic logic [3:0] reg_sel(input logic [2:0] r);
    return SEL_R0 + {1'b0, r};
  endfunction

  function automatic logic [7:0] reg_onehot(input logic [2:0] r);
    return 8'd1 << r;
  endfunction

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic [1:0] alu_op_of(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/unidade_de_controle_decodificador_instrucao.sv
// Combinational mapping of (state, IR, g_nz) onto the datapath select/enable lines.
// UNIDADE_DE_CONTROLE_MVNZ_EN enables the conditional move; otherwise opcode 110 is a NOP.
module decodificador_instrucao
  import unidade_de_controle_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] ir,
  input  logic        g_nz,
  output logic [3:0]  mux_select,
  output logic [7:0]  regs_enable,
  output logic [1:0]  alu_op_select,
  output logic        a_reg_enable,
  output logic        alu_reg_enable,
  output logic        done
);

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  assign opcode = ir[15:13];
  assign rx     = ir[12:10];
  assign ry     = ir[9:7];

  // Immediate bits go straight to the datapath; they never affect control.
`ifdef UNIDADE_DE_CONTROLE_MVNZ_EN
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[6:0];
`else
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[6:0], g_nz};
`endif

  always_comb begin
    mux_select     = SEL_IMM;
    regs_enable    = 8'd0;
    alu_op_select  = ALU_ADD;
    a_reg_enable   = 1'b0;
    alu_reg_enable = 1'b0;
    done           = 1'b0;
    case (state)
      T1: begin
        case (opcode)
          OP_MV: begin
            mux_select  = reg_sel(ry);
            regs_enable = reg_onehot(rx);
            done        = 1'b1;
          end
          OP_MVI: begin
            mux_select  = SEL_IMM;
            regs_enable = reg_onehot(rx);
            done        = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            mux_select   = reg_sel(rx);
            a_reg_enable = 1'b1;
          end
`ifdef UNIDADE_DE_CONTROLE_MVNZ_EN
          OP_MVNZ: begin
            mux_select  = reg_sel(ry);
            regs_enable = g_nz ? reg_onehot(rx) : 8'd0;
            done        = 1'b1;
          end
          OP_NOP: done = 1'b1;
`else
          OP_MVNZ, OP_NOP: done = 1'b1;
`endif
          default: done = 1'b1;
        endcase
      end
      T2: begin
        mux_select     = reg_sel(ry);
        alu_op_select  = alu_op_of(opcode);
        alu_reg_enable = 1'b1;
      end
      T3: begin
        mux_select  = SEL_G;
        regs_enable = reg_onehot(rx);
        done        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_de_controle.sv
// Multi-cycle control unit: run/done handshake, instruction register and step FSM.
// Define UNIDADE_DE_CONTROLE_MVNZ_EN to execute opcode 110 as MVNZ instead of NOP.
module unidade_de_controle
  import unidade_de_controle_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] iin,
  input  logic        g_nz,
  output logic [3:0]  mux_select,
  output logic [7:0]  regs_enable,
  output logic [1:0]  alu_op_select,
  output logic        a_reg_enable,
  output logic        alu_reg_enable,
  output logic        done,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          ir_d    = iin;
          state_d = T1;
        end
      end
      T1:      state_d = is_alu_op(ir_q[15:13]) ? T2 : IDLE;
      T2:      state_d = T3;
      T3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign busy = (state_q != IDLE);

  decodificador_instrucao u_decodificador_instrucao (
    .state          (state_q),
    .ir             (ir_q),
    .g_nz           (g_nz),
    .mux_select     (mux_select),
    .regs_enable    (regs_enable),
    .alu_op_select  (alu_op_select),
    .a_reg_enable   (a_reg_enable),
    .alu_reg_enable (alu_reg_enable),
    .done           (done)
  );

endmodule

// File: tb/tb_unidade_de_controle.sv
// Scoreboard bench for unidade_de_controle: per-cycle expected output vectors are queued
// when stimulus is driven and popped when the cycle's outputs are sampled.
module tb_unidade_de_controle;

  logic        clock = 1'b0;
  logic        resetn, run, g_nz;
  logic [15:0] iin;
  logic [3:0]  mux_select;
  logic [7:0]  regs_enable;
  logic [1:0]  alu_op_select;
  logic        a_reg_enable, alu_reg_enable, done, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] exp_q[$];
  logic [17:0] outs;

  unidade_de_controle dut (
    .clock          (clock),
    .resetn         (resetn),
    .run            (run),
    .iin            (iin),
    .g_nz           (g_nz),
    .mux_select     (mux_select),
    .regs_enable    (regs_enable),
    .alu_op_select  (alu_op_select),
    .a_reg_enable   (a_reg_enable),
    .alu_reg_enable (alu_reg_enable),
    .done           (done),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  assign outs = {mux_select, regs_enable, alu_op_select, a_reg_enable, alu_reg_enable, done, busy};

  // {mux, regs, alu_op, a_en, g_en, done, busy}
  function automatic logic [17:0] ev(input logic [3:0] m, input logic [7:0] r, input logic [1:0] al,
                                     input logic a, input logic g, input logic d, input logic b);
    return {m, r, al, a, g, d, b};
  endfunction

  // Reference sequence of execute-step outputs for one instruction, straight from the ISA table.
  function automatic void push_instr(input logic [15:0] ins, input logic gz);
    logic [2:0] op;
    logic [3:0] sx, sy;
    logic [7:0] ox;
    logic [2:0] opm2;
    op   = ins[15:13];
    sx   = {1'b0, ins[12:10]} + 4'd1;
    sy   = {1'b0, ins[9:7]} + 4'd1;
    ox   = 8'd1 << ins[12:10];
    opm2 = op - 3'd2;
    case (op)
      3'd0: exp_q.push_back(ev(sy, ox, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      3'd1: exp_q.push_back(ev(4'd0, ox, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      3'd2, 3'd3, 3'd4, 3'd5: begin
        exp_q.push_back(ev(sx, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(ev(sy, 8'd0, opm2[1:0], 1'b0, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(ev(4'd9, ox, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      end
`ifdef UNIDADE_DE_CONTROLE_MVNZ_EN
      3'd6: exp_q.push_back(ev(sy, gz ? ox : 8'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
`else
      3'd6: exp_q.push_back(ev(4'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
`endif
      default: exp_q.push_back(ev(4'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    endcase
  endfunction

  task automatic test_reset();
    logic [17:0] got, expv;
    logic [2:0]  rst_s[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        run_s[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      resetn = rst_s[i][0]; run = run_s[i]; iin = 16'h4500; g_nz = 1'b0;
      case (i)
        3:       exp_q.push_back(ev(4'd2, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        4:       exp_q.push_back(ev(4'd3, 8'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        default: exp_q.push_back(18'd0);
      endcase
      #3; got = outs; expv = exp_q.pop_front(); n_checks++;
      if (got !== expv) begin
        n_errors++;
        $display("FAIL reset cycle %0d: got %h required %h", i, got, expv);
      end
    end
  endtask

  task automatic test_mvi();
    logic [17:0] got, expv;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      run = (i == 0); iin = (i == 0) ? 16'h2C05 : 16'hFFFF; g_nz = 1'b0;
      if (i == 1) exp_q.push_back(ev(4'd0, 8'b0000_1000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      else        exp_q.push_back(18'd0);
      #3; got = outs; expv = exp_q.pop_front(); n_checks++;
      if (got !== expv) begin
        n_errors++;
        $display("FAIL mvi cycle %0d: got %h required %h", i, got, expv);
      end
    end
  endtask

  task automatic test_add();
    logic [17:0] got, expv;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      run = (i == 0); iin = 16'h4500; g_nz = 1'b0;
      case (i)
        1:       exp_q.push_back(ev(4'd2, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        2:       exp_q.push_back(ev(4'd3, 8'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        3:       exp_q.push_back(ev(4'd9, 8'b0000_0010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        default: exp_q.push_back(18'd0);
      endcase
      #3; got = outs; expv = exp_q.pop_front(); n_checks++;
      if (got !== expv) begin
        n_errors++;
        $display("FAIL add cycle %0d: got %h required %h", i, got, expv);
      end
    end
  endtask

  // run stays high across MV R0,R7 and SUB R4,R5; iin is scrambled while busy.
  task automatic test_back_to_back();
    logic [17:0] got, expv;
    logic [15:0] iin_s[8] = '{16'h0380, 16'h7280, 16'h7280, 16'h2C05, 16'hE000, 16'h0380, 16'h0380, 16'h0380};
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      run = (i < 5); iin = iin_s[i]; g_nz = 1'b0;
      case (i)
        1:       exp_q.push_back(ev(4'd8, 8'b0000_0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        3:       exp_q.push_back(ev(4'd5, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        4:       exp_q.push_back(ev(4'd6, 8'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1));
        5:       exp_q.push_back(ev(4'd9, 8'b0001_0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        default: exp_q.push_back(18'd0);
      endcase
      #3; got = outs; expv = exp_q.pop_front(); n_checks++;
      if (got !== expv) begin
        n_errors++;
        $display("FAIL back_to_back cycle %0d: got %h required %h", i, got, expv);
      end
    end
  endtask

  task automatic test_mvnz();
    logic [17:0] got, expv;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(18'd0);
      push_instr(16'hD880, k[0]);
      for (int i = 0; i < 3; i++) begin
        @(posedge clock); #1;
        run = (i == 0); iin = 16'hD880; g_nz = k[0];
        if (i == 2) exp_q.push_back(18'd0);
        #3; got = outs; expv = exp_q.pop_front(); n_checks++;
        if (got !== expv) begin
          n_errors++;
          $display("FAIL mvnz g_nz=%0d cycle %0d: got %h required %h", k, i, got, expv);
        end
      end
    end
  endtask

  task automatic test_nop_random();
    logic [17:0] got, expv;
    logic [15:0] ins;
    logic        gz;
    for (int k = 0; k < 40; k++) begin
      ins = (k == 0) ? 16'hE000 : 16'($urandom);
      gz  = 1'($urandom_range(0, 1));
      exp_q.push_back(18'd0);
      push_instr(ins, gz);
      for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
        @(posedge clock); #1;
        run = (c == 0); iin = (c == 0) ? ins : 16'($urandom); g_nz = gz;
        #3; got = outs; expv = exp_q.pop_front(); n_checks++;
        if (got !== expv) begin
          n_errors++;
          $display("FAIL random instr %0d (%h) step %0d: got %h required %h", k, ins, c, got, expv);
        end
        n_checks++;
        if (got[17:14] >= 4'd10) begin
          n_errors++;
          $display("FAIL mux_range instr %0d: got %0d required <10", k, got[17:14]);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0; run = 1'b0; iin = 16'd0; g_nz = 1'b0;
    test_reset();
    test_mvi();
    test_add();
    test_back_to_back();
    test_mvnz();
    test_nop_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
